// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding, mux select constants and data width for the GCD unit
package gcd_pkg;

    localparam int DATA_W = 16;

    localparam logic SEL_DATA_IN = 1'b1;
    localparam logic SEL_SUB     = 1'b0;
    localparam logic SEL_A       = 1'b1;
    localparam logic SEL_B       = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/gcd_control_if.sv
// rtl/gcd_control_if.sv - handshake, comparator flag and datapath control bundle of the GCD controller
interface gcd_control_if #(
    parameter int ITER_W = 16
) ();

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              less_than;
    logic              equal;
    logic              greater_than;
    logic              sel_in;
    logic              load_a;
    logic              load_b;
    logic              sel_a_in_x;
    logic              sel_a_in_y;
    logic              busy;
    logic              done;
    logic              error;
    logic [ITER_W-1:0] iter_count;

    modport master (
        input  start, in_valid, less_than, equal, greater_than,
        output in_ready, sel_in, load_a, load_b, sel_a_in_x, sel_a_in_y,
        output busy, done, error, iter_count
    );

    modport slave (
        output start, in_valid, less_than, equal, greater_than,
        input  in_ready, sel_in, load_a, load_b, sel_a_in_x, sel_a_in_y,
        input  busy, done, error, iter_count
    );

endinterface

// File: rtl/gcd_data.sv
// rtl/gcd_data.sv - GCD datapath: operand registers A/B, shared subtractor and comparator flags
module gcd_data
    import gcd_pkg::*;
(
    input  logic              clock,
    input  logic [DATA_W-1:0] data_in,
    input  logic              sel_in,
    input  logic              load_a,
    input  logic              load_b,
    input  logic              sel_a_in_x,
    input  logic              sel_a_in_y,
    output logic              less_than,
    output logic              equal,
    output logic              greater_than,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out
);

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] sub_x;
    logic [DATA_W-1:0] sub_y;
    logic [DATA_W-1:0] reg_in;

    assign sub_x  = (sel_a_in_x == SEL_A) ? a_q : b_q;
    assign sub_y  = (sel_a_in_y == SEL_A) ? a_q : b_q;
    assign reg_in = (sel_in == SEL_DATA_IN) ? data_in : (sub_x - sub_y);

    assign less_than    = (a_q < b_q);
    assign equal        = (a_q == b_q);
    assign greater_than = (a_q > b_q);
    assign a_out        = a_q;
    assign b_out        = b_q;

    // Operand registers are deliberately unreset; a reset leaves stale operands behind.
    always_ff @(posedge clock) begin
        if (load_a) begin
            a_q <= reg_in;
        end
        if (load_b) begin
            b_q <= reg_in;
        end
    end

endmodule

// File: rtl/gcd_iter_counter.sv
// rtl/gcd_iter_counter.sv - saturating subtraction counter with clear and at-limit flag
module gcd_iter_counter #(
    parameter int                ITER_W   = 16,
    parameter logic [ITER_W-1:0] MAX_ITER = '1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              inc_i,
    output logic [ITER_W-1:0] count_o,
    output logic              at_max_o
);

    logic [ITER_W-1:0] count_q;
    logic [ITER_W-1:0] count_d;

    assign at_max_o = (count_q == MAX_ITER);
    assign count_o  = count_q;

    // Clear wins over increment; increment stops at the limit so the count never wraps.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !at_max_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gcd_control.sv
// rtl/gcd_control.sv - GCD control FSM: operand load handshake and subtract-until-equal iteration
module gcd_control
    import gcd_pkg::*;
#(
    parameter int                ITER_W   = 16,
    parameter logic [ITER_W-1:0] MAX_ITER = '1
) (
    input  logic          clock,
    input  logic          reset_n,
    gcd_control_if.master ctrl
);

    state_e state_q;
    state_e state_d;
    logic   cnt_clear;
    logic   cnt_inc;
    logic   at_max;

    gcd_iter_counter #(
        .ITER_W  (ITER_W),
        .MAX_ITER(MAX_ITER)
    ) u_iter_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear_i (cnt_clear),
        .inc_i   (cnt_inc),
        .count_o (ctrl.iter_count),
        .at_max_o(at_max)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every output decodes from state_q, so an asynchronous reset clears them all at once.
    always_comb begin
        state_d         = state_q;
        cnt_clear       = 1'b0;
        cnt_inc         = 1'b0;
        ctrl.in_ready   = 1'b0;
        ctrl.sel_in     = SEL_SUB;
        ctrl.load_a     = 1'b0;
        ctrl.load_b     = 1'b0;
        ctrl.sel_a_in_x = SEL_B;
        ctrl.sel_a_in_y = SEL_B;
        ctrl.done       = 1'b0;
        ctrl.error      = 1'b0;
        ctrl.busy       = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl.start) begin
                    state_d = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                ctrl.in_ready = 1'b1;
                ctrl.sel_in   = SEL_DATA_IN;
                if (ctrl.in_valid) begin
                    ctrl.load_a = 1'b1;
                    state_d     = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                ctrl.in_ready = 1'b1;
                ctrl.sel_in   = SEL_DATA_IN;
                if (ctrl.in_valid) begin
                    ctrl.load_b = 1'b1;
                    cnt_clear   = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ctrl.equal) begin
                    state_d = ST_DONE;
                end else if (at_max) begin
                    state_d = ST_ERROR;
                end else if (ctrl.greater_than) begin
                    ctrl.sel_a_in_x = SEL_A;
                    ctrl.sel_a_in_y = SEL_B;
                    ctrl.load_a     = 1'b1;
                    cnt_inc         = 1'b1;
                end else if (ctrl.less_than) begin
                    ctrl.sel_a_in_x = SEL_B;
                    ctrl.sel_a_in_y = SEL_A;
                    ctrl.load_b     = 1'b1;
                    cnt_inc         = 1'b1;
                end
            end
            ST_DONE: begin
                ctrl.done = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_ERROR: begin
                ctrl.done  = 1'b1;
                ctrl.error = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_control.sv
// tb/tb_gcd_control.sv - directed bench for gcd_control paired with gcd_data
module tb_gcd_control;
    import gcd_pkg::*;

    localparam int          ITER_W = 16;
    localparam logic [15:0] TB_MAX = 16'd16;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] b_val;

    int tests = 0;
    int fails = 0;

    int r_la, r_lb, r_done, r_err, r_nla, r_nlb, r_bad, r_rdy, r_a, r_iter;
    int r_busy_after, r_done_after;
    int done_seen;

    gcd_control_if #(.ITER_W(ITER_W)) bus ();

    always #5 clock = ~clock;

    gcd_control #(
        .ITER_W  (ITER_W),
        .MAX_ITER(TB_MAX)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .ctrl   (bus.master)
    );

    gcd_data dp (
        .clock       (clock),
        .data_in     (data_in),
        .sel_in      (bus.sel_in),
        .load_a      (bus.load_a),
        .load_b      (bus.load_b),
        .sel_a_in_x  (bus.sel_a_in_x),
        .sel_a_in_y  (bus.sel_a_in_y),
        .less_than   (bus.less_than),
        .equal       (bus.equal),
        .greater_than(bus.greater_than),
        .a_out       (a_val),
        .b_out       (b_val)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start in cycle 0, feed operands (optionally stalling), record event cycles and RUN steering.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int stall, input bit mid);
        int cyc;
        int idx;
        int stall_left;
        r_la = -1; r_lb = -1; r_done = -1; r_err = 0;
        r_nla = 0; r_nlb = 0; r_bad = 0; r_rdy = 0; r_a = 0; r_iter = 0;
        @(posedge clock); #1;
        bus.start    = 1'b1;
        bus.in_valid = (stall == 0);
        data_in      = a;
        cyc = 0; idx = 0; stall_left = stall;
        while (cyc < 60 && r_done < 0) begin
            @(posedge clock); #1;
            cyc++;
            bus.start = mid && (r_lb >= 0) && (cyc == r_lb + 2);
            data_in   = (idx == 0) ? a : b;
            if (bus.in_ready) begin
                if (stall_left > 0) begin
                    bus.in_valid = 1'b0;
                    stall_left--;
                end else begin
                    bus.in_valid = 1'b1;
                end
            end else begin
                bus.in_valid = (stall == 0);
            end
            #1;
            if (bus.in_ready) r_rdy++;
            if (bus.in_ready && bus.in_valid) begin
                if (idx == 0 && bus.load_a && !bus.load_b) r_la = cyc;
                if (idx == 1 && bus.load_b && !bus.load_a) r_lb = cyc;
                idx++;
                stall_left = stall;
            end else if (bus.busy && !bus.in_ready && !bus.done) begin
                r_nla += int'(bus.load_a);
                r_nlb += int'(bus.load_b);
                if (bus.equal || bus.iter_count == TB_MAX) begin
                    if (bus.load_a || bus.load_b || bus.sel_a_in_x || bus.sel_a_in_y || bus.sel_in) r_bad++;
                end else if (bus.greater_than) begin
                    if (!(bus.load_a && !bus.load_b && !bus.sel_in && bus.sel_a_in_x && !bus.sel_a_in_y)) r_bad++;
                end else if (bus.less_than) begin
                    if (!(bus.load_b && !bus.load_a && !bus.sel_in && !bus.sel_a_in_x && bus.sel_a_in_y)) r_bad++;
                end
            end
            if (bus.done) begin
                r_done = cyc;
                r_err  = int'(bus.error);
                r_a    = int'(a_val);
                r_iter = int'(bus.iter_count);
            end
        end
        @(posedge clock); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        r_busy_after = int'(bus.busy);
        r_done_after = int'(bus.done);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        data_in      = '0;

        #3;
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_loads", {bus.load_a, bus.load_b}, 0);
        check("rst_sels", {bus.sel_in, bus.sel_a_in_x, bus.sel_a_in_y}, 0);
        check("rst_done_err", {bus.done, bus.error}, 0);
        check("rst_iter", bus.iter_count, 0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op(16'd12, 16'd8, 0, 1'b0);
        check("12_8_load_a_cyc", r_la, 1);
        check("12_8_load_b_cyc", r_lb, 2);
        check("12_8_done_cyc", r_done, 6);
        check("12_8_result", r_a, 4);
        check("12_8_iter", r_iter, 2);
        check("12_8_error", r_err, 0);
        check("12_8_steer", r_bad, 0);
        check("12_8_done_pulse", r_done_after, 0);

        run_op(16'd7, 16'd7, 0, 1'b0);
        check("7_7_done_cyc", r_done, 4);
        check("7_7_result", r_a, 7);
        check("7_7_iter", r_iter, 0);
        check("7_7_run_loads", r_nla + r_nlb, 0);

        run_op(16'd17, 16'd5, 0, 1'b0);
        check("17_5_done_cyc", r_done, 10);
        check("17_5_result", r_a, 1);
        check("17_5_iter", r_iter, 6);
        check("17_5_loads_a", r_nla, 4);
        check("17_5_loads_b", r_nlb, 2);
        check("17_5_steer", r_bad, 0);
        check("17_5_error", r_err, 0);

        run_op(16'd0, 16'd5, 0, 1'b0);
        check("0_5_done_cyc", r_done, 20);
        check("0_5_error", r_err, 1);
        check("0_5_iter", r_iter, 16);
        check("0_5_loads_a", r_nla, 0);
        check("0_5_loads_b", r_nlb, 16);
        check("0_5_result", r_a, 0);
        check("0_5_steer", r_bad, 0);
        check("0_5_iter_hold", bus.iter_count, 16);

        run_op(16'd12, 16'd8, 3, 1'b1);
        check("stall_load_a_cyc", r_la, 4);
        check("stall_load_b_cyc", r_lb, 8);
        check("stall_ready_cycles", r_rdy, 8);
        check("stall_done_cyc", r_done, 12);
        check("stall_result", r_a, 4);
        check("stall_mid_start_idle", r_busy_after, 0);

        @(posedge clock); #1;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        data_in      = 16'd100;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        data_in = 16'd3;
        repeat (3) @(posedge clock);
        #1;
        check("rst_mid_busy_before", bus.busy, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_loads", {bus.load_a, bus.load_b, bus.in_ready}, 0);
        check("rst_mid_iter", bus.iter_count, 0);
        bus.in_valid = 1'b0;
        done_seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.done) done_seen = 1;
        end
        check("rst_mid_no_done", done_seen, 0);
        reset_n = 1'b1;

        run_op(16'd9, 16'd6, 0, 1'b0);
        check("9_6_done_cyc", r_done, 6);
        check("9_6_result", r_a, 3);
        check("9_6_iter", r_iter, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
